// File: rtl/viterbi_traceback.sv
// Viterbi traceback unit: walks the survivor path backward from a best
// end state for TB_DEPTH stages, storing one decoded bit per stage in a
// LIFO, then replays the bits in chronological order on a serial output.
module viterbi_traceback #(
  parameter int STATE_BITS = 8,
  parameter int NUM_STATES = 256,
  parameter int TB_DEPTH   = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en_t,
  input  logic                             i_start,
  input  logic [STATE_BITS-1:0]            i_start_st,
  input  logic                             i_prv_valid,
  input  logic [NUM_STATES*STATE_BITS-1:0] i_bck_prv_st,
  output logic                             o_bit,
  output logic                             o_valid,
  output logic                             o_done,
  output logic                             o_busy,
  output logic                             o_ovf
);

  localparam int PTR_W = $clog2(TB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACE = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;

  logic [1:0]            state;
  logic [STATE_BITS-1:0] cur_st;
  logic [CNT_W-1:0]      stage_cnt;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  lifo [TB_DEPTH];
  logic                  push;
  logic [STATE_BITS-1:0] prv_st;

  // A stage is consumed only while tracing and the survivor read is valid.
  assign push = rst && en_t && (state == TRACE) && i_prv_valid;

  // Predecessor of the current state; every state index is a legal entry.
  assign prv_st = i_bck_prv_st[32'(cur_st) * STATE_BITS +: STATE_BITS];

  // LIFO write: decoded bit is the LSB of the state being left.
  // NOTE: the LIFO has no reset on purpose; its contents are always written
  // before they are read, so a reset would only cost a huge reset tree.
  always_ff @(posedge clk) begin
    if (push) lifo[stage_cnt[PTR_W-1:0]] <= cur_st[0];
  end

  // Control FSM, path state, replay pointer and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch reads the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cur_st    <= '0;
      stage_cnt <= '0;
      rd_ptr    <= '0;
      o_bit     <= 1'b0;
      o_valid   <= 1'b0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
      o_ovf     <= 1'b0;
    end else if (en_t) begin
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      case (state)
        IDLE: begin
          // Busy drops the cycle after o_done unless a new block starts.
          o_busy <= i_start;
          if (i_prv_valid) o_ovf <= 1'b1;
          if (i_start) begin
            cur_st    <= i_start_st;
            stage_cnt <= '0;
            state     <= TRACE;
          end
        end
        TRACE: begin
          if (i_start) o_ovf <= 1'b1;
          if (i_prv_valid) begin
            cur_st    <= prv_st;
            stage_cnt <= stage_cnt + 1'b1;
            if (stage_cnt == CNT_W'(TB_DEPTH - 1)) begin
              rd_ptr <= PTR_W'(TB_DEPTH - 1);
              state  <= EMIT;
            end
          end
        end
        EMIT: begin
          if (i_start || i_prv_valid) o_ovf <= 1'b1;
          o_bit   <= lifo[rd_ptr];
          o_valid <= 1'b1;
          rd_ptr  <= rd_ptr - 1'b1;
          if (rd_ptr == '0) begin
            o_done <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback: table of traceback blocks with
// a scoreboard of expected bits, plus hand sequences for reset, overflow,
// enable stall and start/valid collision.
module tb_viterbi_traceback;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_t;
  logic          i_start;
  logic [7:0]    i_start_st;
  logic          i_prv_valid;
  logic [2047:0] i_bck_prv_st;
  logic          o_bit, o_valid, o_done, o_busy, o_ovf;

  viterbi_traceback dut (
    .clk(clk), .rst(rst), .en_t(en_t), .i_start(i_start),
    .i_start_st(i_start_st), .i_prv_valid(i_prv_valid),
    .i_bck_prv_st(i_bck_prv_st), .o_bit(o_bit), .o_valid(o_valid),
    .o_done(o_done), .o_busy(o_busy), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;
  int cyc = 0;
  int start_cyc, first_cyc, vcnt, ones;
  bit done_seen;
  bit exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference survivor tables: predecessor of state s for each table kind.
  function automatic logic [7:0] nxt(input int kind, input logic [7:0] s);
    case (kind)
      1:       return s >> 1;
      2:       return {s[6:0], 1'b1};
      3:       return s ^ 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  // Output monitor: pops the scoreboard on every enabled o_valid cycle.
  always @(negedge clk) begin
    if (rst && en_t && o_valid) begin
      vcnt++;
      if (vcnt == 1) first_cyc = cyc;
      ones += int'(o_bit);
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else check("bit", o_bit, exp_q.pop_front());
      if (o_done) begin
        done_seen = 1'b1;
        check("done_position", vcnt, 64);
      end
    end else if (rst && en_t && o_done) begin
      check("done_without_valid", 1, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one block; called and returns 1 time unit after a rising edge.
  task automatic run_block(input logic [7:0] s0, input int kind, input bit gap,
                           input int stall_at, input int inj_at, input bit start_valid);
    logic [7:0] cur;
    bit b[64];
    bit stalled = 1'b0;
    bit inj = 1'b0;
    for (int s = 0; s < 256; s++) i_bck_prv_st[s*8 +: 8] = nxt(kind, 8'(s));
    cur = s0;
    for (int k = 0; k < 64; k++) begin
      b[k] = cur[0];
      cur  = nxt(kind, cur);
    end
    for (int k = 63; k >= 0; k--) exp_q.push_back(b[k]);
    vcnt = 0; ones = 0; done_seen = 1'b0; first_cyc = -1;
    i_start = 1'b1; i_start_st = s0; i_prv_valid = start_valid;
    tick();
    start_cyc = cyc;
    i_start = 1'b0; i_prv_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (gap) tick();
      i_prv_valid = 1'b1;
      tick();
      i_prv_valid = 1'b0;
    end
    check("busy_in_block", o_busy, 1);
    for (int t = 0; t < 400 && !done_seen; t++) begin
      if (stall_at >= 0 && vcnt == stall_at && !stalled) begin
        en_t = 1'b0;
        repeat (5) tick();
        en_t = 1'b1;
        stalled = 1'b1;
      end else if (inj_at >= 0 && vcnt == inj_at && !inj) begin
        i_start = 1'b1; i_start_st = 8'hAA;
        tick();
        i_start = 1'b0;
        inj = 1'b1;
      end else begin
        tick();
      end
    end
    check("done_seen", done_seen, 1);
    check("valid_count", vcnt, 64);
    tick();
    check("busy_after_done", o_busy, 0);
    check("valid_after_done", o_valid, 0);
  endtask

  typedef struct {
    logic [7:0] start_st;
    int         kind;
    bit         gap;
    int         exp_lat;
    int         exp_ones;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h00, 0, 1'b0, 65, 0};
    vecs[1] = '{8'hFF, 1, 1'b0, 65, 8};
    vecs[2] = '{8'hFF, 1, 1'b1, 129, 8};
    vecs[3] = '{8'h00, 2, 1'b0, 65, 63};
    vecs[4] = '{8'h01, 3, 1'b0, 65, 32};

    rst = 1'b0; en_t = 1'b1; i_start = 1'b0; i_start_st = '0;
    i_prv_valid = 1'b0; i_bck_prv_st = '0;
    repeat (3) tick();
    check("rst_bit", o_bit, 0);
    check("rst_valid", o_valid, 0);
    check("rst_done", o_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ovf", o_ovf, 0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_block(vecs[i].start_st, vecs[i].kind, vecs[i].gap, -1, -1, 1'b0);
      check("latency", first_cyc - start_cyc, vecs[i].exp_lat);
      check("ones", ones, vecs[i].exp_ones);
      check("ovf_clean", o_ovf, 0);
      tick();
    end

    // Reset in the middle of TRACE, then a fresh all-zero block.
    for (int s = 0; s < 256; s++) i_bck_prv_st[s*8 +: 8] = 8'h00;
    i_start = 1'b1; i_start_st = 8'h00;
    tick();
    i_start = 1'b0;
    i_prv_valid = 1'b1;
    repeat (30) tick();
    i_prv_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("midrst_busy", o_busy, 0);
    check("midrst_valid", o_valid, 0);
    check("midrst_ovf", o_ovf, 0);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    run_block(8'h00, 0, 1'b0, -1, -1, 1'b0);
    check("postrst_ones", ones, 0);
    check("postrst_ovf", o_ovf, 0);

    // Enable held low for 5 cycles in the middle of EMIT.
    run_block(8'hFF, 1, 1'b0, 20, -1, 1'b0);
    check("stall_ones", ones, 8);
    check("stall_ovf", o_ovf, 0);

    // i_start during EMIT: ignored, overflow flagged, stream unchanged.
    run_block(8'h01, 3, 1'b0, -1, 10, 1'b0);
    check("inj_ones", ones, 32);
    check("inj_ovf", o_ovf, 1);

    // i_prv_valid while idle: ignored, overflow stays set, no output.
    i_prv_valid = 1'b1;
    tick();
    i_prv_valid = 1'b0;
    repeat (3) tick();
    check("idle_prv_busy", o_busy, 0);
    check("idle_prv_ovf", o_ovf, 1);

    // Start and stage together while idle: start taken, stage dropped.
    run_block(8'h00, 2, 1'b0, -1, -1, 1'b1);
    check("collide_latency", first_cyc - start_cyc, 65);
    check("collide_ones", ones, 63);
    check("collide_ovf", o_ovf, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/viterbi_traceback.md
# viterbi_traceback

Traceback unit of the Viterbi decoder datapath. It consumes one trellis stage of survivor previous-state pointers per valid cycle from the survivor-path memory read port, starting from a given best state. It walks the survivor path backward for TB_DEPTH stages and extracts one decoded bit per stage into a LIFO. It then replays those bits in forward (chronological) order on a serial valid-qualified output.

## Interface
- STATE_BITS, 8: width of a state index; NUM_STATES = 2**STATE_BITS.
- NUM_STATES, 256: number of trellis states; entries per stage.
- TB_DEPTH, 64: stages walked per traceback block; LIFO depth in bits.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- en_t  in  1  block enable; when 0, all state holds (no advance, no output change).
- i_start  in  1  one-cycle pulse: begin a traceback block from i_start_st.
- i_start_st  in  STATE_BITS  best-metric end state, sampled when i_start=1.
- i_prv_valid  in  1  qualifies i_bck_prv_st as the next stage, newest stage first.
- i_bck_prv_st  in  NUM_STATES x STATE_BITS  survivor pointer array; entry s = predecessor of state s.
- o_bit  out  1  decoded bit, forward order.
- o_valid  out  1  o_bit valid this cycle.
- o_done  out  1  one-cycle pulse with the last o_valid of a block.
- o_busy  out  1  high in TRACE and EMIT.
- o_ovf  out  1  sticky: i_prv_valid or i_start arrived while not accepted.

## Operation
- FSM states: IDLE, TRACE, EMIT.
- IDLE: on en_t & i_start, load cur_st <= i_start_st, stage_cnt <= 0, go TRACE.
- TRACE: on each en_t & i_prv_valid cycle:
  - push cur_st[0] into LIFO at index stage_cnt;
  - update cur_st <= i_bck_prv_st[cur_st];
  - increment stage_cnt.
  - When the push makes stage_cnt reach TB_DEPTH, go EMIT with rd_ptr <= TB_DEPTH-1.
  - Cycles without i_prv_valid stall the block with no change.
- EMIT: each en_t cycle, drive o_bit = lifo[rd_ptr] and o_valid=1, then decrement rd_ptr. At rd_ptr==0, assert o_done and go IDLE.
- Decoded bit is the LSB of the state being left (newest input bit). The first stage traced is the last bit emitted.
- stage_cnt is 7 bits, rd_ptr 6 bits (log2 TB_DEPTH). No wrap: stage_cnt never exceeds TB_DEPTH.
- i_bck_prv_st is indexed by the full STATE_BITS cur_st; all indices are legal.
- i_start in TRACE or EMIT is ignored and sets o_ovf. i_prv_valid in IDLE or EMIT is ignored and sets o_ovf.
- i_start and i_prv_valid in the same IDLE cycle: start is taken and that stage is dropped; o_ovf sets.
- o_ovf clears only on reset.

## Timing
- Reset (rst=0 at a clk edge), including mid-TRACE or mid-EMIT:
  - FSM goes to IDLE;
  - cur_st, stage_cnt, rd_ptr go to 0;
  - o_bit, o_valid, o_done, o_busy, o_ovf go to 0;
  - LIFO contents are don't-care.
- o_busy is registered: 1 from the cycle after the accepted i_start until the cycle after o_done.
- TRACE with i_prv_valid continuous: TB_DEPTH cycles. The first o_valid appears 1 cycle after the TB_DEPTH-th accepted stage.
- EMIT: exactly TB_DEPTH consecutive o_valid cycles (if en_t held); o_done coincides with the last.
- Minimum block: 1 (start) + TB_DEPTH + TB_DEPTH cycles. A new i_start is accepted the cycle after o_done.
- en_t=0 freezes everything; o_valid/o_done hold their registered values but must be counted only when en_t=1.

## Test plan
- All entries 0, i_start_st=0, 64 back-to-back valid stages -> 64 o_valid with o_bit=0, o_done on the 64th, o_ovf=0.
- Entry s = s>>1 every stage, i_start_st=0xFF -> trace bits 1×8 then 0×56; emitted order 0×56 then 1×8; first o_valid exactly 65 cycles after i_start.
- Same as previous but i_prv_valid deasserted every other cycle -> identical bit stream; TRACE lasts 128 cycles.
- Reset pulse at stage 30 of TRACE, then fresh all-zero block -> outputs 0 during reset, no stale bits, 64 zeros emitted, o_ovf=0.
- i_start during EMIT, and i_prv_valid during IDLE -> both ignored, o_ovf=1 and sticky, current block output unchanged.
- en_t low for 5 cycles mid-EMIT -> bit sequence continues unchanged after en_t returns; total o_valid-with-en_t count is 64.
